fb_scanout: RTL

FB_SCANOUT -- requirements
Module: fb_scanout

---
 rtl/fb_scanout.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fb_scanout.sv
// 640x480@60 scanout of a 32x32 cell framebuffer with a one-entry host write slot.
// Host writes are committed to the framebuffer RAM only while the beam is in blanking.
//
// wr_state | meaning
// WR_IDLE  | slot empty, wr_ready high
// WR_PEND  | host write held, waiting for blanking to commit
module fb_scanout #(
  parameter int CELL_W = 20,
  parameter int CELL_H = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [9:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic [9:0] ram_addr,
  output logic [3:0] ram_din,
  output logic       ram_we,
  input  logic [3:0] ram_dout,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [2:0] vga_b,
  output logic       frame_start
);

  localparam int HCW = $clog2(CELL_W + 1);
  localparam int VCW = $clog2(CELL_H + 1);

  typedef enum logic {WR_IDLE, WR_PEND} wr_state_t;

  wr_state_t      wr_state, wr_state_nxt;
  logic           running;
  logic [9:0]     h, v;
  logic [HCW-1:0] hc;
  logic [VCW-1:0] vc;
  logic [4:0]     col, row;
  logic [9:0]     hold_addr;
  logic [3:0]     hold_data;
  logic           h_wrap, v_wrap, act_c, hs_c, vs_c;
  logic           accept, commit;
  logic           act1, hs1, vs1, act2, hs2, vs2;

  assign h_wrap = (h == 10'd799);
  assign v_wrap = (v == 10'd524);
  // The hold cycle right after reset release is treated as blanking.
  assign act_c  = running && (h < 10'd640) && (v < 10'd480);
  assign hs_c   = !((h >= 10'd656) && (h <= 10'd751));
  assign vs_c   = !((v >= 10'd490) && (v <= 10'd491));

  // Counters hold at (0,0) for one clk after release so frame_start marks the first frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running     <= 1'b0;
      frame_start <= 1'b0;
      h           <= '0;
      v           <= '0;
      hc          <= '0;
      vc          <= '0;
      col         <= '0;
      row         <= '0;
    end else begin
      running     <= 1'b1;
      frame_start <= !running || (h_wrap && v_wrap);
      if (running) begin
        if (h_wrap) begin
          h   <= '0;
          hc  <= '0;
          col <= '0;
          if (v_wrap) begin
            v   <= '0;
            vc  <= '0;
            row <= '0;
          end else begin
            v <= v + 10'd1;
            if (vc == VCW'(CELL_H - 1)) begin
              vc  <= '0;
              row <= row + 5'd1;
            end else begin
              vc <= vc + VCW'(1);
            end
          end
        end else begin
          h <= h + 10'd1;
          if (hc == HCW'(CELL_W - 1)) begin
            hc  <= '0;
            col <= col + 5'd1;
          end else begin
            hc <= hc + HCW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_state <= WR_IDLE;
    else     wr_state <= wr_state_nxt;
  end

  always_comb begin
    wr_state_nxt = wr_state;
    accept       = 1'b0;
    commit       = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (wr_valid) begin
          accept       = 1'b1;
          wr_state_nxt = WR_PEND;
        end
      end
      WR_PEND: begin
        if (!act_c) begin
          commit       = 1'b1;
          wr_state_nxt = WR_IDLE;
        end
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  assign wr_ready = (wr_state == WR_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_addr <= '0;
      hold_data <= '0;
    end else if (accept) begin
      hold_addr <= wr_addr;
      hold_data <= wr_data;
    end
  end

  // Stage 1: RAM address/write port, shared between scanout reads and commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      act1     <= 1'b0;
      hs1      <= 1'b1;
      vs1      <= 1'b1;
    end else begin
      ram_we <= commit;
      act1   <= act_c;
      hs1    <= hs_c;
      vs1    <= vs_c;
      if (commit) begin
        ram_addr <= hold_addr;
        ram_din  <= hold_data;
      end else begin
        ram_addr <= {row, col};
      end
    end
  end

  // Stage 2 waits on RAM read data; stage 3 registers the palette lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act2      <= 1'b0;
      hs2       <= 1'b1;
      vs2       <= 1'b1;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
    end else begin
      act2      <= act1;
      hs2       <= hs1;
      vs2       <= vs1;
      vga_hsync <= hs2;
      vga_vsync <= vs2;
      if (act2) begin
        vga_r <= {ram_dout[2], ram_dout[3], ram_dout[2]};
        vga_g <= {ram_dout[1], ram_dout[3], ram_dout[1]};
        vga_b <= {ram_dout[0], ram_dout[3], ram_dout[0]};
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

endmodule
